// File: rtl/zero_scan.sv
// zero_scan
// ---------------------------------------------------------------------------
// Multi-cycle zero detector and leading-zero counter. A WIDTH-bit word is
// accepted over a valid/ready handshake, then scanned MSB-first CHUNK bits
// per cycle. The scan stops at the first chunk that holds a set bit. The
// result (is_zero, lz_count) is returned over a second valid/ready handshake.
// Only one word is in flight at a time.
//
// Parameters
//   WIDTH  data word width (>= 1)
//   CHUNK  bits examined per scan cycle; must divide WIDTH exactly
//   LZW    derived width of lz_count, $clog2(WIDTH+1)
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   data_in is presented
//   in_ready   block can accept a word (IDLE only)
//   data_in    word to test, sampled on the accept edge
//   out_valid  result is presented (DONE only)
//   out_ready  consumer takes the result
//   is_zero    accepted word was all zeros
//   lz_count   leading zeros from the MSB, WIDTH when is_zero
// ---------------------------------------------------------------------------
module zero_scan #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    localparam int LZW  = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_zero,
    output logic [LZW-1:0]   lz_count
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep idx at least one bit wide so CHUNK == WIDTH still elaborates.
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("zero_scan: CHUNK must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [IW-1:0]    idx;
    logic [LZW-1:0]   acc;

    logic [CHUNK-1:0] top;
    logic [LZW-1:0]   chunk_lz;

    assign top = sh[WIDTH-1 -: CHUNK];

    // Priority encoder over the top chunk: walking LSB to MSB, the last set
    // bit seen is the highest one, so it wins. Only meaningful when top != 0.
    always_comb begin
        // NOTE: default assignment first so every path drives chunk_lz and
        // no latch is inferred.
        chunk_lz = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (top[i]) begin
                chunk_lz = LZW'(CHUNK - 1 - i);
            end
        end
    end

    // Handshake outputs are pure state decodes, so no input reaches an
    // output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // The scan registers are cleared too, not just the state, so an
            // in-flight word is fully discarded rather than left dormant.
            state    <= IDLE;
            sh       <= '0;
            idx      <= '0;
            acc      <= '0;
            is_zero  <= 1'b0;
            lz_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh    <= data_in;
                        idx   <= '0;
                        acc   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (top != '0) begin
                        // acc + chunk_lz <= WIDTH-1, so it fits in LZW bits.
                        lz_count <= acc + chunk_lz;
                        is_zero  <= 1'b0;
                        state    <= DONE;
                    end else if (idx == IW'(NCHUNK - 1)) begin
                        lz_count <= LZW'(WIDTH);
                        is_zero  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        acc <= acc + LZW'(CHUNK);
                        sh  <= sh << CHUNK;
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    // in_valid is deliberately ignored here; the next word
                    // can only be taken once back in IDLE.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
